// File: rtl/uart_tx_serializer.sv
// UART transmit back end: a byte FIFO fed by THR writes, drained by an 8N1
// serializer. Also reports THR-empty / transmitter-empty for LSR bits 5 and 6.
module uart_tx_serializer #(
  parameter int CLKS_PER_BIT = 868,
  parameter int FIFO_AW      = 4
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_wr_en,
  input  logic [7:0]         i_wr_data,
  output logic               o_full,
  output logic               o_overrun,
  output logic [FIFO_AW:0]   o_count,
  output logic               o_thr_empty,
  output logic               o_tx_idle,
  output logic               o_tx
);

  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW    = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0]    BAUD_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [FIFO_AW:0] FULL_CNT  = (FIFO_AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  logic [7:0]         mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   count;
  logic               overrun_q;

  state_t             state, state_nxt;
  logic [CW-1:0]      baud_cnt;
  logic [2:0]         bit_idx;
  logic [7:0]         shift;
  logic               tx_q, tx_nxt;
  logic               push, pop, baud_done, have_data;

  assign push      = i_wr_en && !o_full;
  assign have_data = (count != '0);
  assign baud_done = (baud_cnt == BAUD_LAST);

  // Storage needs no reset; the pointers define what is valid.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_wr_data;
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= i_wr_en && o_full;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shift    <= '0;
      tx_q     <= 1'b1;
    end else begin
      state <= state_nxt;
      tx_q  <= tx_nxt;
      if (state == IDLE || baud_done) baud_cnt <= '0;
      else                            baud_cnt <= baud_cnt + 1'b1;
      if (state != DATA)  bit_idx <= '0;
      else if (baud_done) bit_idx <= bit_idx + 1'b1;
      if (pop)                             shift <= mem[rd_ptr];
      else if (state == DATA && baud_done) shift <= shift >> 1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:  if (have_data) state_nxt = START;
      START: if (baud_done) state_nxt = DATA;
      DATA:  if (baud_done && bit_idx == 3'd7) state_nxt = STOP;
      STOP:  if (baud_done) state_nxt = have_data ? START : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // The line level is computed one edge ahead so o_tx is a clean flop output.
  always_comb begin
    pop    = 1'b0;
    tx_nxt = tx_q;
    case (state)
      IDLE: begin
        tx_nxt = 1'b1;
        if (have_data) begin
          pop    = 1'b1;
          tx_nxt = 1'b0;
        end
      end
      START: if (baud_done) tx_nxt = shift[0];
      DATA:  if (baud_done) tx_nxt = (bit_idx == 3'd7) ? 1'b1 : shift[1];
      STOP: begin
        if (baud_done) begin
          pop    = have_data;
          tx_nxt = !have_data;
        end
      end
      default: tx_nxt = 1'b1;
    endcase
  end

  assign o_full      = (count == FULL_CNT);
  assign o_overrun   = overrun_q;
  assign o_count     = count;
  assign o_thr_empty = !have_data;
  assign o_tx_idle   = !have_data && (state == IDLE);
  assign o_tx        = tx_q;

endmodule

// File: tb/tb_uart_tx_serializer.sv
// Directed bench for uart_tx_serializer at 4 clocks per bit: per-cycle frame
// vectors from a table, then multi-frame, overflow and reset corner sequences.
module tb_uart_tx_serializer;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full, overrun, thr_empty, tx_idle, tx;
  logic [4:0] count;

  int n_checks = 0;
  int n_fail   = 0;
  int frame_err = 0;
  logic [7:0] rx_q[$];

  typedef struct {
    logic [7:0] data;
    logic [9:0] line;
  } vec_t;
  vec_t vecs[7];

  always #5 clk = ~clk;

  uart_tx_serializer #(.CLKS_PER_BIT(N), .FIFO_AW(4)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_wr_en(wr_en), .i_wr_data(wr_data),
    .o_full(full), .o_overrun(overrun), .o_count(count),
    .o_thr_empty(thr_empty), .o_tx_idle(tx_idle), .o_tx(tx)
  );

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic [7:0] d);
    wr_en   = wr;
    wr_data = d;
    waitCycles(1);
  endtask

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic waitIdle(input int bound, output int cyc);
    cyc = 0;
    while (tx_idle !== 1'b1 && cyc < bound) begin
      applyStimulus(1'b0, 8'h00);
      cyc++;
    end
    checkOutput("idle_wait", {31'd0, tx_idle}, 32'd1);
  endtask

  // Independent line decoder: samples each bit mid-period after a start edge.
  always begin : monitor
    logic [7:0] b;
    @(posedge clk);
    #1;
    if (rst_n === 1'b1 && tx === 1'b0) begin
      waitCycles(N / 2);
      for (int i = 0; i < 8; i++) begin
        waitCycles(N);
        b[i] = tx;
      end
      waitCycles(N);
      if (tx === 1'b1) rx_q.push_back(b);
      else frame_err++;
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int cyc, max_cnt;
    logic [7:0] exp_b;

    vecs[0] = '{8'h41, 10'b1010000010};
    vecs[1] = '{8'h00, 10'b1000000000};
    vecs[2] = '{8'hFF, 10'b1111111110};
    vecs[3] = '{8'hA5, 10'b1101001010};
    vecs[4] = '{8'h80, 10'b1100000000};
    vecs[5] = '{8'h01, 10'b1000000010};
    vecs[6] = '{8'h3C, 10'b1001111000};

    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    applyStimulus(1'b0, 8'h00);
    checkOutput("rst tx", {31'd0, tx}, 32'd1);
    checkOutput("rst count", {27'd0, count}, 32'd0);
    checkOutput("rst thr_empty", {31'd0, thr_empty}, 32'd1);
    checkOutput("rst tx_idle", {31'd0, tx_idle}, 32'd1);
    checkOutput("rst full", {31'd0, full}, 32'd0);
    checkOutput("rst overrun", {31'd0, overrun}, 32'd0);
    rst_n = 1'b1;
    applyStimulus(1'b0, 8'h00);

    // Single frames, checked on every clock of the 10-bit frame.
    for (int v = 0; v < 7; v++) begin
      applyStimulus(1'b1, vecs[v].data);
      checkOutput($sformatf("v%0d E0 thr_empty", v), {31'd0, thr_empty}, 32'd0);
      checkOutput($sformatf("v%0d E0 tx_idle", v), {31'd0, tx_idle}, 32'd0);
      checkOutput($sformatf("v%0d E0 count", v), {27'd0, count}, 32'd1);
      checkOutput($sformatf("v%0d E0 tx", v), {31'd0, tx}, 32'd1);
      for (int k = 0; k < 10 * N; k++) begin
        applyStimulus(1'b0, 8'h00);
        checkOutput($sformatf("v%0d tx k%0d", v, k), {31'd0, tx}, {31'd0, vecs[v].line[k / N]});
        if (k == 0) begin
          checkOutput($sformatf("v%0d E1 thr_empty", v), {31'd0, thr_empty}, 32'd1);
          checkOutput($sformatf("v%0d E1 count", v), {27'd0, count}, 32'd0);
        end
        if (k == 0 || k == 10 * N - 1)
          checkOutput($sformatf("v%0d busy k%0d", v, k), {31'd0, tx_idle}, 32'd0);
      end
      applyStimulus(1'b0, 8'h00);
      checkOutput($sformatf("v%0d end tx_idle", v), {31'd0, tx_idle}, 32'd1);
      checkOutput($sformatf("v%0d end tx", v), {31'd0, tx}, 32'd1);
      checkOutput($sformatf("v%0d decoded", v), {24'd0, rx_q[rx_q.size() - 1]}, {24'd0, vecs[v].data});
    end
    checkOutput("table rx count", rx_q.size(), 32'd7);
    rx_q.delete();

    // Back-to-back: three frames with no gap, 120 cycles after the first pop.
    applyStimulus(1'b1, 8'h55);
    max_cnt = count;
    applyStimulus(1'b1, 8'hAA);
    if (count > max_cnt) max_cnt = count;
    applyStimulus(1'b1, 8'h0F);
    if (count > max_cnt) max_cnt = count;
    cyc = 2;
    while (tx_idle !== 1'b1 && cyc < 600) begin
      applyStimulus(1'b0, 8'h00);
      cyc++;
      if (count > max_cnt) max_cnt = count;
    end
    checkOutput("b2b duration", cyc, 32'd121);
    checkOutput("b2b peak count", max_cnt, 32'd2);
    checkOutput("b2b rx size", rx_q.size(), 32'd3);
    if (rx_q.size() == 3) begin
      checkOutput("b2b byte0", {24'd0, rx_q[0]}, 32'h55);
      checkOutput("b2b byte1", {24'd0, rx_q[1]}, 32'hAA);
      checkOutput("b2b byte2", {24'd0, rx_q[2]}, 32'h0F);
    end
    rx_q.delete();

    // Overflow: 18 consecutive pushes, only the last is rejected.
    for (int i = 0; i < 18; i++) begin
      applyStimulus(1'b1, 8'(i));
      checkOutput($sformatf("ovf count i%0d", i), {27'd0, count},
                  (i == 0) ? 32'd1 : ((i > 16) ? 32'd16 : 32'(i)));
      checkOutput($sformatf("ovf full i%0d", i), {31'd0, full}, (i >= 16) ? 32'd1 : 32'd0);
      checkOutput($sformatf("ovf overrun i%0d", i), {31'd0, overrun}, (i == 17) ? 32'd1 : 32'd0);
    end
    applyStimulus(1'b0, 8'h00);
    checkOutput("ovf overrun clears", {31'd0, overrun}, 32'd0);
    checkOutput("ovf still full", {31'd0, full}, 32'd1);
    waitIdle(2000, cyc);
    checkOutput("ovf rx size", rx_q.size(), 32'd17);
    for (int i = 0; i < rx_q.size() && i < 17; i++)
      checkOutput($sformatf("ovf byte%0d", i), {24'd0, rx_q[i]}, 32'(i));
    rx_q.delete();

    // Push lands exactly on the final STOP edge while 3 bytes are queued.
    applyStimulus(1'b1, 8'h11);
    applyStimulus(1'b1, 8'h22);
    applyStimulus(1'b1, 8'h33);
    applyStimulus(1'b1, 8'h44);
    wr_en = 1'b0;
    waitCycles(37);
    checkOutput("sim pre count", {27'd0, count}, 32'd3);
    checkOutput("sim pre tx stop", {31'd0, tx}, 32'd1);
    applyStimulus(1'b1, 8'h5A);
    wr_en = 1'b0;
    checkOutput("sim count held", {27'd0, count}, 32'd3);
    checkOutput("sim next start", {31'd0, tx}, 32'd0);
    waitIdle(1000, cyc);
    checkOutput("sim rx size", rx_q.size(), 32'd5);
    if (rx_q.size() == 5) begin
      exp_b = 8'h11;
      for (int i = 0; i < 4; i++) begin
        checkOutput($sformatf("sim byte%0d", i), {24'd0, rx_q[i]}, {24'd0, exp_b});
        exp_b = exp_b + 8'h11;
      end
      checkOutput("sim byte4", {24'd0, rx_q[4]}, 32'h5A);
    end
    checkOutput("framing errors", frame_err, 32'd0);
    rx_q.delete();

    // Reset during data bit 3 of 0xF7 (bit 3 is 0) with two bytes queued.
    applyStimulus(1'b1, 8'hF7);
    applyStimulus(1'b1, 8'hC1);
    applyStimulus(1'b1, 8'hC2);
    wr_en = 1'b0;
    waitCycles(16);
    checkOutput("mid bit3", {31'd0, tx}, 32'd0);
    checkOutput("mid count", {27'd0, count}, 32'd2);
    rst_n = 1'b0;
    applyStimulus(1'b0, 8'h00);
    rst_n = 1'b1;
    checkOutput("abort tx", {31'd0, tx}, 32'd1);
    checkOutput("abort count", {27'd0, count}, 32'd0);
    checkOutput("abort tx_idle", {31'd0, tx_idle}, 32'd1);
    cyc = 0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 8'h00);
      if (tx !== 1'b1 || tx_idle !== 1'b1) cyc++;
    end
    checkOutput("abort quiet cycles", cyc, 32'd0);
    rx_q.delete();
    applyStimulus(1'b1, 8'h3C);
    waitIdle(200, cyc);
    checkOutput("post-reset rx size", rx_q.size(), 32'd1);
    if (rx_q.size() == 1) checkOutput("post-reset byte", {24'd0, rx_q[0]}, 32'h3C);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_tx_serializer.md
Name: uart_tx_serializer

Overview:
- Transmit back end fed by the UART register block.
- Each byte the CPU writes to THR is pushed here, queued in a small FIFO and shifted out as 8N1 serial frames on a single TX line.
- Returns THR-empty and transmitter-empty status for LSR bits 5 and 6, replacing the hardwired "THR empty" of the simulation model.

Parameters:
- CLKS_PER_BIT, 868, i_clk cycles per serial bit (100 MHz / 115200); must be >= 2.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW (16).

Ports:
- i_clk  input  1  system clock, all logic on rising edge.
- i_rst_n  input  1  reset, synchronous, active-low.
- i_wr_en  input  1  push strobe: one byte per cycle while high (THR write).
- i_wr_data  input  8  byte to push.
- o_full  output  1  FIFO holds 2**FIFO_AW bytes.
- o_overrun  output  1  one-cycle pulse: push rejected because FIFO full.
- o_count  output  FIFO_AW+1  bytes currently queued (excludes byte in shifter).
- o_thr_empty  output  1  FIFO empty (LSR bit 5).
- o_tx_idle  output  1  FIFO empty and serializer IDLE (LSR bit 6).
- o_tx  output  1  serial line, registered, idle high.

Behaviour:
- Reset, i_rst_n low at a rising edge:
  - FIFO pointers and o_count clear to 0; o_full=0; o_overrun=0.
  - State goes to IDLE; baud counter and bit index clear to 0.
  - o_tx=1, o_thr_empty=1, o_tx_idle=1.
  - Reset mid-frame aborts the frame: o_tx is 1 after that edge and queued bytes are discarded.
- FIFO:
  - Push when i_wr_en=1 and o_full=0: write i_wr_data at the write pointer; pointer wraps modulo depth.
  - i_wr_en=1 while o_full=1: byte dropped, o_overrun=1 for exactly the next cycle. This holds even when a pop occurs the same cycle, since full status is the pre-edge value.
  - Pop is performed only by the FSM (see below).
  - Push and pop in the same cycle with count in 1..depth-1: count unchanged, both pointers advance.
  - Push to an empty FIFO is never bypassed: the byte is always written first.
  - o_full, o_thr_empty and o_tx_idle are combinational from registered count/state.
- FSM states: IDLE, START, DATA, STOP.
  - IDLE: o_tx=1. If count>0 at an edge: pop the head byte into the 8-bit shift register, state goes to START, o_tx=0, baud counter=0.
  - START: hold for CLKS_PER_BIT cycles, then go to DATA with o_tx=shift[0] and bit index=0.
  - DATA: each bit is held CLKS_PER_BIT cycles, LSB first. After bit index 7 completes, go to STOP with o_tx=1.
  - STOP: hold CLKS_PER_BIT cycles. At its final edge:
    - count>0: pop and go directly to START (no idle gap).
    - otherwise: go to IDLE.
- Baud counter: $clog2(CLKS_PER_BIT) bits; counts 0..CLKS_PER_BIT-1, wraps on bit completion.
- Frame length: exactly 10*CLKS_PER_BIT cycles.
- Latency:
  - Push at edge E0 into an empty FIFO with the FSM in IDLE: pop at E1, o_tx low from E1.
  - Between E0 and E1, o_thr_empty=0 and o_tx_idle=0.
  - After E1, o_thr_empty=1 again, but o_tx_idle stays 0 until the final STOP edge.
- Pushes never stall the shifter; the shifter never reads an empty FIFO.

Test Plan:
- Reset check: hold i_rst_n=0 two cycles -> o_tx=1, o_count=0, o_thr_empty=1, o_tx_idle=1, o_full=0, o_overrun=0.
- Single byte, CLKS_PER_BIT=4: push 0x41 at E0 ->
  - o_tx=0 for cycles E1..E1+3.
  - Then bits 1,0,0,0,0,0,1,0 at 4 cycles each, then stop=1 for 4 cycles.
  - o_tx_idle returns to 1 at E1+40.
- Back-to-back: push 0x55, 0xAA, 0x0F on three consecutive cycles ->
  - o_count peaks at 2.
  - Three contiguous frames, 120 cycles, no idle gap.
  - Decoded bytes match in order.
- Overflow: push 18 bytes 0x00..0x11 on consecutive cycles while idle ->
  - First pops at cycle 2, so o_full first asserts with 16 queued.
  - Pushes made while o_full=1 are dropped, each with a one-cycle o_overrun pulse.
  - Line carries exactly 17 bytes (shifter byte + 16), in order.
- Simultaneous push/pop: FIFO count=3, push on the exact STOP-final edge ->
  - o_count stays 3.
  - Next frame carries the old head byte; new byte queued last.
- Reset mid-frame: i_rst_n=0 during DATA bit 3 with 2 bytes queued ->
  - o_tx=1 the next cycle, o_count=0.
  - No further frames start until a new push.
